// File: rtl/router_pkg.sv
// Shared sizing defaults and header length-field layout for the router FIFO.
package router_pkg;
   localparam int ROUTER_WIDTH = 8;
   localparam int ROUTER_DEPTH = 16;
   localparam int LEN_MSB      = 7;
   localparam int LEN_LSB      = 2;
   localparam int CNT_W        = 7;

   typedef logic [CNT_W-1:0] pkt_cnt_t;

   // Bytes still owed after a header: payload length plus the trailing parity byte.
   function automatic pkt_cnt_t hdr_to_cnt(input logic [LEN_MSB-LEN_LSB:0] len);
      return pkt_cnt_t'(len) + pkt_cnt_t'(1);
   endfunction
endpackage

// File: rtl/router_fifo_mem.sv
// Router FIFO storage: one write port, one registered read port with a synchronous clear.
// Read latency 1; no flow control of its own, the caller qualifies every enable.
module router_fifo_mem
   import router_pkg::*;
#(
   parameter int WIDTH = ROUTER_WIDTH,
   parameter int DEPTH = ROUTER_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic           clock,
   input  logic           resetn,
   input  logic           wr_en_i,
   input  logic [AW-1:0]  wr_addr_i,
   input  logic [WIDTH:0] wr_dat_i,
   input  logic           rd_en_i,
   input  logic [AW-1:0]  rd_addr_i,
   input  logic           rd_clr_i,
   output logic [WIDTH:0] rd_dat_o
);
   logic [WIDTH:0] mem_q [DEPTH];
   logic [WIDTH:0] rd_dat_q;

   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_dat_i;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rd_dat_q <= '0;
      end else if (rd_clr_i) begin
         rd_dat_q <= '0;
      end else if (rd_en_i) begin
         rd_dat_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_dat_o = rd_dat_q;
endmodule

// File: rtl/router_fifo.sv
// Router output FIFO with header-tagged entries and packet byte counter; data_out 1 cycle after read.
// Writes while full / reads while empty are dropped. Optional almost_full via ROUTER_FIFO_ALMOST_FULL_EN.
module router_fifo
   import router_pkg::*;
#(
   parameter int WIDTH = ROUTER_WIDTH,
   parameter int DEPTH = ROUTER_DEPTH
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             soft_reset,
   input  logic             write_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-1:0] data_in,
   input  logic             read_enb,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
`ifdef ROUTER_FIFO_ALMOST_FULL_EN
   ,
   output logic             almost_full
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]  wptr_q, wptr_d;
   logic [PW-1:0]  rptr_q, rptr_d;
   pkt_cnt_t       cnt_q, cnt_d;
   logic           rd_vld_q;
   logic           wr_acc, rd_acc, rd_clr;
   logic [WIDTH:0] rd_dat;

   assign empty  = (wptr_q == rptr_q);
   assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign wr_acc = write_enb && !full;
   assign rd_acc = read_enb && !empty;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (soft_reset) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (wr_acc) wptr_d = wptr_q + PW'(1);
         if (rd_acc) rptr_d = rptr_q + PW'(1);
      end
   end

   // The entry read last edge only becomes visible in the read register now, so cnt_q
   // trails by one read; cnt_d folds that read in and is the true packet count.
   always_comb begin
      cnt_d = cnt_q;
      if (rd_vld_q) begin
         if (rd_dat[WIDTH]) begin
            cnt_d = hdr_to_cnt(rd_dat[LEN_MSB:LEN_LSB]);
         end else if (cnt_q != '0) begin
            cnt_d = cnt_q - pkt_cnt_t'(1);
         end
      end
   end

   assign rd_clr = soft_reset || (!rd_acc && (cnt_d == '0));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         rd_vld_q <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         cnt_q    <= soft_reset ? '0 : cnt_d;
         rd_vld_q <= rd_acc && !soft_reset;
      end
   end

   router_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clock     (clock),
      .resetn    (resetn),
      .wr_en_i   (wr_acc && !soft_reset),
      .wr_addr_i (wptr_q[AW-1:0]),
      .wr_dat_i  ({lfd_state, data_in}),
      .rd_en_i   (rd_acc),
      .rd_addr_i (rptr_q[AW-1:0]),
      .rd_clr_i  (rd_clr),
      .rd_dat_o  (rd_dat)
   );

   assign data_out = rd_dat[WIDTH-1:0];

`ifdef ROUTER_FIFO_ALMOST_FULL_EN
   logic [PW-1:0] occ;
   assign occ         = wptr_q - rptr_q;
   assign almost_full = (occ >= PW'(DEPTH - 1));
`endif
endmodule
